// File: rtl/lcd16x2_refresh_ctrl_if.sv
// Character buffer write port for the 16x2 LCD refresh controller.
// One write per cycle while wr_en is high.
interface lcd16x2_refresh_ctrl_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/lcd16x2_refresh_ctrl.sv
// HD44780 16x2 sequencer: power-up wait, init commands, then
// endless two-line refresh from a 32-byte character buffer.
module lcd16x2_refresh_ctrl #(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 2,
  parameter int EN_CYC         = 12,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 205000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  lcd16x2_refresh_ctrl_if.slave wr,
  input  logic       bl_on,
  output logic [7:0] lcd_data,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic       lcd_blon,
  output logic       init_done,
  output logic       frame_done
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(
    max2(max2(POWERUP_CYC, SETUP_CYC),
         max2(EN_CYC, SHORT_WAIT_CYC)),
    LONG_WAIT_CYC);
  localparam int CW = $clog2(MAXP + 1);

  localparam logic [CW-1:0] LD_PWR =
    CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] LD_SETUP =
    CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN =
    CW'(EN_CYC - 1);
  localparam logic [CW-1:0] LD_SHORT =
    CW'(SHORT_WAIT_CYC - 1);
  localparam logic [CW-1:0] LD_LONG =
    CW'(LONG_WAIT_CYC - 1);

  typedef enum logic [1:0] {
    S_PWR,
    S_SETUP,
    S_EN,
    S_WAIT
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [5:0]      idx_q;
  logic [5:0]      idx_d;
  logic            done_d;
  logic            frame_d;
  logic            load;
  logic            long_wait;
  logic            item_rs;
  logic [7:0]      item_data;
  logic [4:0]      baddr;
  logic [7:0]      char_q [32];

  assign lcd_rw = 1'b0;

  // First function set and clear need the long settle time.
  assign long_wait = !init_done &&
                     (idx_q == 6'd0 || idx_q == 6'd5);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = init_done;
    frame_d = 1'b0;
    load    = 1'b0;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      unique case (state_q)
        S_PWR: begin
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
          idx_d   = 6'd0;
          load    = 1'b1;
        end
        S_SETUP: begin
          state_d = S_EN;
          cnt_d   = LD_EN;
        end
        S_EN: begin
          state_d = S_WAIT;
          cnt_d   = long_wait ? LD_LONG : LD_SHORT;
        end
        S_WAIT: begin
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
          load    = 1'b1;
          if (!init_done && idx_q == 6'd6) begin
            done_d = 1'b1;
            idx_d  = 6'd0;
          end else if (init_done && idx_q == 6'd33) begin
            frame_d = 1'b1;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      endcase
    end
  end

  // Item for the transfer about to enter SETUP; the buffer is
  // sampled here, so a write on the same edge is not seen.
  always_comb begin
    item_rs   = 1'b0;
    item_data = 8'h00;
    baddr     = 5'd0;
    if (!done_d) begin
      case (idx_d)
        6'd0, 6'd1,
        6'd2, 6'd3: item_data = 8'h38;
        6'd4:       item_data = 8'h0C;
        6'd5:       item_data = 8'h01;
        default:    item_data = 8'h06;
      endcase
    end else begin
      unique case (1'b1)
        (idx_d == 6'd0):  item_data = 8'h80;
        (idx_d == 6'd17): item_data = 8'hC0;
        default: begin
          item_rs = 1'b1;
          baddr = (idx_d < 6'd17) ?
                  5'(idx_d - 6'd1) :
                  5'(idx_d - 6'd2);
          item_data = char_q[baddr];
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= S_PWR;
      cnt_q      <= LD_PWR;
      idx_q      <= 6'd0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      lcd_on     <= 1'b0;
      lcd_blon   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      init_done  <= done_d;
      frame_done <= frame_d;
      lcd_en     <= (state_d == S_EN);
      lcd_on     <= 1'b1;
      lcd_blon   <= bl_on;
      if (load) begin
        lcd_rs   <= item_rs;
        lcd_data <= item_data;
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < 32; i++) begin
        char_q[i] <= 8'h20;
      end
    end else if (wr.wr_en) begin
      char_q[wr.wr_addr] <= wr.wr_data;
    end
  end

endmodule

// File: tb/tb_lcd16x2_refresh_ctrl.sv
// Directed bench for lcd16x2_refresh_ctrl with shortened timing
// (POWERUP 10, SETUP 1, EN 2, SHORT 4, LONG 8).
module tb_lcd16x2_refresh_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bl_on = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_on;
  logic       lcd_blon;
  logic       init_done;
  logic       frame_done;

  lcd16x2_refresh_ctrl_if wr_if ();

  lcd16x2_refresh_ctrl #(
    .POWERUP_CYC    (10),
    .SETUP_CYC      (1),
    .EN_CYC         (2),
    .SHORT_WAIT_CYC (4),
    .LONG_WAIT_CYC  (8)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .wr          (wr_if.slave),
    .bl_on       (bl_on),
    .lcd_data    (lcd_data),
    .lcd_en      (lcd_en),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_on      (lcd_on),
    .lcd_blon    (lcd_blon),
    .init_done   (init_done),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         base = 0;
  int         tests = 0;
  int         fails = 0;
  bit         en_prev = 1'b0;
  logic [7:0] mdl [32];

  function automatic int rel();
    return cyc - base;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    en_prev = lcd_en;
    @(negedge clk);
  endtask

  task automatic wait_until(input int k);
    while (rel() < k) tick();
  endtask

  task automatic get_pulse(output logic [7:0] d,
                           output logic rs,
                           output int t);
    int n;
    n = 0;
    tick();
    while (!(lcd_en && !en_prev) && n < 40) begin
      tick();
      n++;
    end
    chk("pulse_seen", 32'(lcd_en && !en_prev), 32'd1);
    d = lcd_data;
    rs = lcd_rs;
    t = rel();
  endtask

  function automatic logic [8:0] exp_item(input int i);
    if (i == 0) return {1'b0, 8'h80};
    if (i == 17) return {1'b0, 8'hC0};
    if (i < 17) return {1'b1, mdl[i-1]};
    return {1'b1, mdl[i-2]};
  endfunction

  task automatic run_init(input string tag);
    int         rises [7];
    logic [7:0] bytes [7];
    logic [7:0] d;
    logic       rs;
    int         t;
    rises = '{11, 22, 29, 36, 43, 50, 61};
    bytes = '{8'h38, 8'h38, 8'h38, 8'h38,
              8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 7; i++) begin
      get_pulse(d, rs, t);
      chk($sformatf("%s_data%0d", tag, i), 32'(d), 32'(bytes[i]));
      chk($sformatf("%s_rs%0d", tag, i), 32'(rs), 32'd0);
      chk($sformatf("%s_rise%0d", tag, i), t, rises[i]);
    end
    wait_until(66);
    chk({tag, "_done_lo"}, 32'(init_done), 32'd0);
    tick();
    chk({tag, "_done_hi"}, 32'(init_done), 32'd1);
  endtask

  task automatic run_frame(input string tag, input int r0,
                           input int n, input bit mid);
    logic [7:0] d;
    logic       rs;
    int         t;
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      get_pulse(d, rs, t);
      e = exp_item(i);
      chk($sformatf("%s_data%0d", tag, i), 32'(d), 32'(e[7:0]));
      chk($sformatf("%s_rs%0d", tag, i), 32'(rs), 32'(e[8]));
      chk($sformatf("%s_rise%0d", tag, i), t, r0 + 7 * i);
      if (i == 0)
        chk({tag, "_fd_width"}, 32'(frame_done), 32'd0);
      if (mid && i == 3) begin
        wr_if.wr_en = 1'b1;
        wr_if.wr_addr = 5'd2;
        wr_if.wr_data = 8'h41;
        tick();
        wr_if.wr_addr = 5'd20;
        wr_if.wr_data = 8'h42;
        mdl[20] = 8'h42;
        tick();
        wr_if.wr_en = 1'b0;
      end
    end
  endtask

  task automatic check_fd(input string tag, input int at);
    wait_until(at - 1);
    chk({tag, "_fd_lo"}, 32'(frame_done), 32'd0);
    tick();
    chk({tag, "_fd_hi"}, 32'(frame_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_if.wr_en = 1'b0;
    wr_if.wr_addr = 5'd0;
    wr_if.wr_data = 8'h00;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;

    repeat (3) @(negedge clk);
    chk("rst_on", 32'(lcd_on), 32'd0);
    chk("rst_en", 32'(lcd_en), 32'd0);
    chk("rst_data", 32'(lcd_data), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);

    rst = 1'b0;
    base = cyc;
    tick();
    chk("pwr_on", 32'(lcd_on), 32'd1);
    chk("pwr_en", 32'(lcd_en), 32'd0);
    chk("pwr_rw", 32'(lcd_rw), 32'd0);
    chk("blon_lo", 32'(lcd_blon), 32'd0);
    bl_on = 1'b1;
    wr_if.wr_en = 1'b1;
    wr_if.wr_addr = 5'd0;
    wr_if.wr_data = 8'h48;
    mdl[0] = 8'h48;
    tick();
    chk("blon_hi", 32'(lcd_blon), 32'd1);
    wr_if.wr_addr = 5'd31;
    wr_if.wr_data = 8'h39;
    mdl[31] = 8'h39;
    tick();
    wr_if.wr_en = 1'b0;

    run_init("init1");
    run_frame("f1", 68, 34, 1'b0);
    check_fd("f1", 305);
    run_frame("f2", 306, 34, 1'b1);
    check_fd("f2", 543);
    mdl[2] = 8'h41;
    run_frame("f3", 544, 34, 1'b0);
    check_fd("f3", 781);
    run_frame("f4", 782, 6, 1'b0);

    chk("pre_rst_en", 32'(lcd_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_en", 32'(lcd_en), 32'd0);
    chk("arst_done", 32'(init_done), 32'd0);
    chk("arst_on", 32'(lcd_on), 32'd0);
    chk("arst_blon", 32'(lcd_blon), 32'd0);
    chk("arst_data", 32'(lcd_data), 32'd0);
    chk("arst_rs", 32'(lcd_rs), 32'd0);
    tick();
    rst = 1'b0;
    base = cyc;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;

    run_init("init2");
    run_frame("f5", 68, 34, 1'b0);
    check_fd("f5", 305);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
